adder_rr_scheduler: RTL and testbench

//  Shares one 4-bit adder between two input FIFO channels (ch0, ch1) and writes results into one output FIFO.

---
 rtl/adder_rr_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_adder_rr_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : adder_rr_scheduler
//  Purpose  : Shares one external 4-bit adder between two FWFT input FIFO
//             channels (ch0, ch1) with round-robin arbitration. Each result
//             is tagged with its source channel and written to one output
//             FIFO. Per-channel completion counters are kept.
//  Ports    : clock, reset      - clock, asynchronous active-high reset
//             chN_empty/rd/din  - input FIFO N: empty flag, pop strobe, head
//                                 word ([3:0]=opA, [7:4]=opB)
//             add_in1/add_in2   - registered adder operands
//             add_out           - adder sum, valid ADD_LAT cycles after issue
//             out_full/wr/dout  - output FIFO: full flag, write strobe, word
//                                 ([DATA_WIDTH-1]=channel tag, [4:0]=sum)
//             busy              - operation in progress (state != IDLE)
//             chN_count         - results written for channel N (wrapping)
//  Revision : 1.0 - initial release
// ============================================================================
module adder_rr_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADD_LAT    = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ch0_empty,
    output logic                  ch0_rd,
    input  logic [DATA_WIDTH-1:0] ch0_din,
    input  logic                  ch1_empty,
    output logic                  ch1_rd,
    input  logic [DATA_WIDTH-1:0] ch1_din,
    output logic [3:0]            add_in1,
    output logic [3:0]            add_in2,
    input  logic [4:0]            add_out,
    input  logic                  out_full,
    output logic                  out_wr,
    output logic [DATA_WIDTH-1:0] out_dout,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  ch0_count,
    output logic [CNT_WIDTH-1:0]  ch1_count
);

    // Wait counter holds ADD_LAT-1 down to 0; at least one bit wide.
    localparam int c_WAIT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(ADD_LAT - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_WRITE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_WAIT  = c_ST_WAIT,
        ST_WRITE = c_ST_WRITE
    } state_t;

    state_t                  r_state_q,   w_state_d;
    logic                    r_grant_q,   w_grant_d;
    logic                    r_last_q,    w_last_d;
    logic                    r_ch0_rd_q,  w_ch0_rd_d;
    logic                    r_ch1_rd_q,  w_ch1_rd_d;
    logic [3:0]              r_add_a_q,   w_add_a_d;
    logic [3:0]              r_add_b_q,   w_add_b_d;
    logic [c_WAIT_W-1:0]     r_wait_q,    w_wait_d;
    logic                    r_out_wr_q,  w_out_wr_d;
    logic [DATA_WIDTH-1:0]   r_dout_q,    w_dout_d;
    logic [CNT_WIDTH-1:0]    r_cnt0_q,    w_cnt0_d;
    logic [CNT_WIDTH-1:0]    r_cnt1_q,    w_cnt1_d;

    logic                    w_req0;
    logic                    w_req1;
    logic                    w_pick;
    logic [DATA_WIDTH-1:0]   w_head;
    logic [DATA_WIDTH-1:0]   w_result;

    // Only the operand byte of each head word is used.
    logic w_unused_din;
    assign w_unused_din = ^{ch0_din[DATA_WIDTH-1:8], ch1_din[DATA_WIDTH-1:8]};

    always_comb begin
        w_state_d  = r_state_q;
        w_grant_d  = r_grant_q;
        w_last_d   = r_last_q;
        w_ch0_rd_d = 1'b0;
        w_ch1_rd_d = 1'b0;
        w_add_a_d  = r_add_a_q;
        w_add_b_d  = r_add_b_q;
        w_wait_d   = r_wait_q;
        w_out_wr_d = 1'b0;
        w_dout_d   = r_dout_q;
        w_cnt0_d   = r_cnt0_q;
        w_cnt1_d   = r_cnt1_q;

        w_req0 = !ch0_empty;
        w_req1 = !ch1_empty;
        // Contention goes to the channel not served last; otherwise to
        // whichever channel is requesting (ch1 when only ch1 requests).
        w_pick = (w_req0 && w_req1) ? ~r_last_q : w_req1;
        w_head = w_pick ? ch1_din : ch0_din;

        w_result      = '0;
        w_result[DATA_WIDTH-1] = r_grant_q;
        w_result[4:0] = add_out;

        case (r_state_q)
            ST_IDLE: begin
                if (w_req0 || w_req1) begin
                    w_grant_d  = w_pick;
                    w_ch0_rd_d = ~w_pick;
                    w_ch1_rd_d = w_pick;
                    w_add_a_d  = w_head[3:0];
                    w_add_b_d  = w_head[7:4];
                    w_wait_d   = c_WAIT_LOAD;
                    w_state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_wait_q == '0) begin
                    w_state_d = ST_WRITE;
                end else begin
                    w_wait_d = r_wait_q - 1'b1;
                end
            end
            ST_WRITE: begin
                // Backpressure simply holds the state; the sum stays on
                // add_out because the operands are not touched.
                if (!out_full) begin
                    w_out_wr_d = 1'b1;
                    w_dout_d   = w_result;
                    if (r_grant_q) begin
                        w_cnt1_d = r_cnt1_q + 1'b1;
                    end else begin
                        w_cnt0_d = r_cnt0_q + 1'b1;
                    end
                    w_last_d  = r_grant_q;
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q  <= ST_IDLE;
            r_grant_q  <= 1'b0;
            r_last_q   <= 1'b1;   // ch0 wins the first contention
            r_ch0_rd_q <= 1'b0;
            r_ch1_rd_q <= 1'b0;
            r_add_a_q  <= '0;
            r_add_b_q  <= '0;
            r_wait_q   <= '0;
            r_out_wr_q <= 1'b0;
            r_dout_q   <= '0;
            r_cnt0_q   <= '0;
            r_cnt1_q   <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_grant_q  <= w_grant_d;
            r_last_q   <= w_last_d;
            r_ch0_rd_q <= w_ch0_rd_d;
            r_ch1_rd_q <= w_ch1_rd_d;
            r_add_a_q  <= w_add_a_d;
            r_add_b_q  <= w_add_b_d;
            r_wait_q   <= w_wait_d;
            r_out_wr_q <= w_out_wr_d;
            r_dout_q   <= w_dout_d;
            r_cnt0_q   <= w_cnt0_d;
            r_cnt1_q   <= w_cnt1_d;
        end
    end

    assign ch0_rd    = r_ch0_rd_q;
    assign ch1_rd    = r_ch1_rd_q;
    assign add_in1   = r_add_a_q;
    assign add_in2   = r_add_b_q;
    assign out_wr    = r_out_wr_q;
    assign out_dout  = r_dout_q;
    assign busy      = (r_state_q != ST_IDLE);
    assign ch0_count = r_cnt0_q;
    assign ch1_count = r_cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_rr_scheduler
//  Purpose  : Self-checking bench for adder_rr_scheduler. Instance dut uses
//             ADD_LAT=1, CNT_WIDTH=4 and is tracked by a transaction model;
//             instance dut3 uses ADD_LAT=3 for the long-latency case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_rr_scheduler;

    localparam int LAT = 1;
    localparam int CW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- instance with ADD_LAT=1, CNT_WIDTH=4 ----------------
    logic          ch0_empty = 1'b1, ch1_empty = 1'b1;
    logic [31:0]   ch0_din = '0, ch1_din = '0;
    logic          ch0_rd, ch1_rd, out_wr, busy;
    logic          out_full;
    logic [3:0]    add_in1, add_in2;
    logic [4:0]    add_out = '0;
    logic [31:0]   out_dout;
    logic [CW-1:0] ch0_count, ch1_count;

    adder_rr_scheduler #(.DATA_WIDTH(32), .ADD_LAT(LAT), .CNT_WIDTH(CW)) dut (
        .clock(clk), .reset(rst),
        .ch0_empty(ch0_empty), .ch0_rd(ch0_rd), .ch0_din(ch0_din),
        .ch1_empty(ch1_empty), .ch1_rd(ch1_rd), .ch1_din(ch1_din),
        .add_in1(add_in1), .add_in2(add_in2), .add_out(add_out),
        .out_full(out_full), .out_wr(out_wr), .out_dout(out_dout),
        .busy(busy), .ch0_count(ch0_count), .ch1_count(ch1_count)
    );

    // ---------------- instance with ADD_LAT=3 ----------------
    logic          b_ch0_empty, b_ch1_empty, b_out_full;
    logic [31:0]   b_ch0_din, b_ch1_din, b_out_dout;
    logic          b_ch0_rd, b_ch1_rd, b_out_wr, b_busy;
    logic [3:0]    b_add_in1, b_add_in2;
    logic [4:0]    b_s1 = '0, b_s2 = '0, b_add_out = '0;
    logic [15:0]   b_ch0_count, b_ch1_count;

    adder_rr_scheduler #(.DATA_WIDTH(32), .ADD_LAT(3), .CNT_WIDTH(16)) dut3 (
        .clock(clk), .reset(rst),
        .ch0_empty(b_ch0_empty), .ch0_rd(b_ch0_rd), .ch0_din(b_ch0_din),
        .ch1_empty(b_ch1_empty), .ch1_rd(b_ch1_rd), .ch1_din(b_ch1_din),
        .add_in1(b_add_in1), .add_in2(b_add_in2), .add_out(b_add_out),
        .out_full(b_out_full), .out_wr(b_out_wr), .out_dout(b_out_dout),
        .busy(b_busy), .ch0_count(b_ch0_count), .ch1_count(b_ch1_count)
    );

    // Adder models: sum appears ADD_LAT clocks after the operands change.
    always @(posedge clk) add_out <= {1'b0, add_in1} + {1'b0, add_in2};
    always @(posedge clk) begin
        b_s1      <= {1'b0, b_add_in1} + {1'b0, b_add_in2};
        b_s2      <= b_s1;
        b_add_out <= b_s2;
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int pcyc  = 0;
    always @(posedge clk) pcyc <= pcyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endfunction

    // ---------------- FWFT input FIFOs ----------------
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    always @(posedge clk) begin
        #1;
        if (ch0_rd && q0.size() > 0) void'(q0.pop_front());
        if (ch1_rd && q1.size() > 0) void'(q1.pop_front());
        ch0_empty = (q0.size() == 0);
        ch1_empty = (q1.size() == 0);
        ch0_din   = (q0.size() != 0) ? q0[0] : 32'h0;
        ch1_din   = (q1.size() != 0) ? q1[0] : 32'h0;
    end

    // ---------------- transaction model + per-cycle compare ----------------
    bit          m_busy = 1'b0, m_prev_busy = 1'b0, m_prev_rst = 1'b1, m_last = 1'b1;
    bit          m_ch = 1'b0;
    logic [3:0]  m_a = '0, m_b = '0;
    int          m_rd_cyc = 0, m_wr_cyc = -1, m_cnt0 = 0, m_cnt1 = 0, cyc = 0;
    logic [31:0] m_dout = '0, m_res;
    bit          p_e0 = 1'b1, p_e1 = 1'b1, g_exp, gch_exp;
    logic [31:0] p_d0 = '0, p_d1 = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check("reset_ctl", {12'b0, ch0_rd, ch1_rd, out_wr, busy, add_in1, add_in2,
                                ch0_count, ch1_count}, 32'h0);
            check("reset_dout", out_dout, 32'h0);
            m_busy = 1'b0; m_wr_cyc = -1; m_last = 1'b1; m_dout = '0;
            m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            // A grant happened at the last edge if the scheduler was idle
            // during the previous cycle and some channel had data then.
            g_exp = !m_prev_busy && !m_prev_rst && (!p_e0 || !p_e1);
            if (!p_e0 && !p_e1)  gch_exp = !m_last;
            else if (!p_e0)      gch_exp = 1'b0;
            else                 gch_exp = 1'b1;
            if (g_exp) begin
                m_busy = 1'b1; m_ch = gch_exp; m_rd_cyc = cyc; m_wr_cyc = -1;
                m_a = gch_exp ? p_d1[3:0] : p_d0[3:0];
                m_b = gch_exp ? p_d1[7:4] : p_d0[7:4];
            end
            check("rd_strobes", {30'b0, ch1_rd, ch0_rd},
                  {30'b0, g_exp && gch_exp, g_exp && !gch_exp});
            if (m_wr_cyc == cyc) begin
                m_res = '0;
                m_res[31]  = m_ch;
                m_res[4:0] = {1'b0, m_a} + {1'b0, m_b};
                m_dout = m_res;
                if (m_ch) m_cnt1 = (m_cnt1 + 1) % (1 << CW);
                else      m_cnt0 = (m_cnt0 + 1) % (1 << CW);
                m_last = m_ch; m_busy = 1'b0; m_wr_cyc = -1;
                check("out_wr", {31'b0, out_wr}, 32'd1);
            end else begin
                check("out_wr", {31'b0, out_wr}, 32'd0);
            end
            check("out_dout", out_dout, m_dout);
            check("ch0_count", 32'(ch0_count), 32'(m_cnt0));
            check("ch1_count", 32'(ch1_count), 32'(m_cnt1));
            check("busy", {31'b0, busy}, {31'b0, m_busy});
            if (m_busy) check("operands", {24'b0, add_in2, add_in1}, {24'b0, m_b, m_a});
            // Result leaves in the first WRITE cycle that sees out_full low.
            if (m_busy && m_wr_cyc < 0 && cyc >= m_rd_cyc + LAT && !out_full)
                m_wr_cyc = cyc + 1;
        end
        m_prev_busy = m_busy;
        m_prev_rst  = rst;
        p_e0 = ch0_empty; p_e1 = ch1_empty; p_d0 = ch0_din; p_d1 = ch1_din;
    end

    // ---------------- helper tasks ----------------
    task automatic wait_rd(input bit which, output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (which ? ch1_rd : ch0_rd) begin c = pcyc; return; end
        end
        fail_now("wait_rd");
    endtask

    task automatic wait_wr(output int c, output logic [31:0] d);
        c = -1; d = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_wr) begin c = pcyc; d = out_dout; return; end
        end
        fail_now("wait_wr");
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (q0.size() == 0 && q1.size() == 0 && ch0_empty && ch1_empty && !busy && !out_wr)
                quiet++;
            else
                quiet = 0;
            if (quiet >= 3) return;
        end
        fail_now("wait_idle");
    endtask

    task automatic do_reset();
        @(posedge clk); #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int          t_rd, t_wr, nwr, nrd, nlow;
        logic [31:0] d;
        rst = 1'b1; out_full = 1'b0;
        b_ch0_empty = 1'b1; b_ch1_empty = 1'b1; b_ch0_din = '0; b_ch1_din = '0;
        b_out_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_b_outputs", {b_ch1_count, 9'b0, b_ch0_rd, b_ch1_rd, b_out_wr, b_busy,
                                b_add_in1 | b_add_in2}, 32'h0);
        check("rst_b_dout", b_out_dout, 32'h0);
        #1 rst = 1'b0;

        // 1: single ch0 word 0x53 -> 3+5
        @(posedge clk); #2 q0.push_back(32'h53);
        wait_rd(1'b0, t_rd);
        wait_wr(t_wr, d);
        check("t1_latency", 32'(t_wr - t_rd), 32'd2);
        check("t1_dout", d, 32'h0000_0008);
        check("t1_count", 32'(ch0_count), 32'd1);

        // 2: both channels loaded after reset -> ch0 first, strict alternation
        do_reset();
        @(posedge clk); #2;
        for (int i = 0; i < 8; i++) begin
            q0.push_back(32'h21);
            q1.push_back(32'hFF);
        end
        wait_wr(t_wr, d);
        check("t2_first", d, 32'h0000_0003);
        wait_wr(t_wr, d);
        check("t2_second", d, 32'h8000_001E);
        wait_idle();
        check("t2_counts", {24'b0, ch0_count, ch1_count}, 32'h0000_0088);

        // 3: output FIFO full while the result waits in WRITE
        @(posedge clk); #2 out_full = 1'b1;
        q0.push_back(32'h34);
        nwr = 0; nrd = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_wr) nwr++;
            if (ch0_rd || ch1_rd) nrd++;
        end
        check("t3_no_write_when_full", 32'(nwr), 32'd0);
        check("t3_busy_held", {31'b0, busy}, 32'd1);
        #1 out_full = 1'b0;
        d = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_wr) begin nwr++; d = out_dout; end
            if (ch0_rd || ch1_rd) nrd++;
        end
        check("t3_single_write", 32'(nwr), 32'd1);
        check("t3_single_pop", 32'(nrd), 32'd1);
        check("t3_dout", d, 32'h0000_0007);
        check("t3_count", 32'(ch0_count), 32'd9);

        // 4: reset during WAIT aborts the operation
        @(posedge clk); #2 q1.push_back(32'h12);
        wait_rd(1'b1, t_rd);
        #2 rst = 1'b1;
        #1;
        check("t4_async_ctl", {12'b0, ch0_rd, ch1_rd, out_wr, busy, add_in1, add_in2,
                               ch0_count, ch1_count}, 32'h0);
        check("t4_async_dout", out_dout, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        nwr = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_wr) nwr++;
        end
        check("t4_no_write", 32'(nwr), 32'd0);
        @(posedge clk); #2;
        q0.push_back(32'h11);
        q1.push_back(32'h22);
        wait_wr(t_wr, d);
        check("t4_ch0_first", d, 32'h0000_0002);
        wait_wr(t_wr, d);
        check("t4_ch1_next", d, 32'h8000_0004);
        wait_idle();

        // 5: 16 ch1 results wrap the 4-bit counter
        do_reset();
        @(posedge clk); #2;
        q0.push_back(32'h99);
        for (int i = 0; i < 16; i++) q1.push_back(32'h11);
        wait_idle();
        check("t5_ch1_wrap", 32'(ch1_count), 32'd0);
        check("t5_ch0_kept", 32'(ch0_count), 32'd1);
        check("t5_last_dout", out_dout, 32'h8000_0002);

        // 6: ADD_LAT=3 instance, ch1 word 0xA7 -> 7+10
        @(posedge clk); #2;
        b_ch1_din = 32'hA7; b_ch1_empty = 1'b0;
        t_rd = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (b_ch1_rd) begin t_rd = pcyc; b_ch1_empty = 1'b1; break; end
        end
        if (t_rd < 0) fail_now("t6_rd");
        t_wr = -1; nlow = 0; d = '0;
        for (int i = 0; i < 20 && t_rd >= 0; i++) begin
            @(posedge clk); #1;
            if (b_out_wr) begin t_wr = pcyc; d = b_out_dout; break; end
            if (!b_busy) nlow++;
        end
        if (t_wr < 0) fail_now("t6_wr");
        check("t6_latency", 32'(t_wr - t_rd), 32'd4);
        check("t6_dout", d, 32'h8000_0011);
        check("t6_busy_throughout", 32'(nlow), 32'd0);
        check("t6_counts", {b_ch0_count, b_ch1_count}, 32'h0000_0001);
        check("t6_operands", {24'b0, b_add_in2, b_add_in1}, 32'h0000_00A7);
        check("t6_no_ch0_rd", {31'b0, b_ch0_rd}, 32'd0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
